// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN accelerator: bank select codes, fixed-point
// formats and the fully-connected stage state encoding.
package cnn_pkg;
  localparam logic [2:0] L0_K0 = 3'd1;
  localparam logic [2:0] L0_K1 = 3'd2;
  localparam logic [2:0] L1_K0 = 3'd3;
  localparam logic [2:0] L1_K1 = 3'd4;
  localparam logic [2:0] L2    = 3'd5;
  localparam logic [2:0] FC    = 3'd6;

  localparam int DATA_W = 20;
  localparam int FRAC_W = 16;
  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W  = 52;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_BIAS,
    ST_ADD_BIAS,
    ST_WRITE,
    ST_DONE
  } fc_state_t;
endpackage

// File: rtl/fc_round_sat.sv
// Converts a Q20.32 accumulator to Q4.16: round half up, saturate, optional ReLU.
module fc_round_sat
  import cnn_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] y
);
  localparam int Q_W = ACC_W - FRAC_W;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC_W - 1));
  localparam logic signed [Q_W-1:0] MAXV = Q_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [Q_W-1:0] MINV = ~MAXV;

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] r;
    logic signed [Q_W-1:0]   q;
    logic signed [DATA_W-1:0] res;
    r = a + HALF;
    q = r[ACC_W-1:FRAC_W];
    if (q > MAXV)      res = MAXV[DATA_W-1:0];
    else if (q < MINV) res = MINV[DATA_W-1:0];
    else               res = q[DATA_W-1:0];
    if (RELU && res[DATA_W-1]) res = '0;
    return res;
  endfunction

  assign y = round_sat(acc);
endmodule

// File: rtl/fc_layer.sv
// Dense layer: streams the flattened input bank against a weight ROM, one MAC
// per clock, then adds bias, rounds/saturates and writes each neuron out.
module fc_layer
  import cnn_pkg::*;
#(
  parameter int         IN_LEN  = 2048,
  parameter int         NUM_OUT = 4,
  parameter bit         RELU    = 1'b1,
  parameter logic [2:0] IN_SEL  = 3'b101,
  parameter logic [2:0] OUT_SEL = 3'b110,
  parameter int         WADDR_W = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     crd,
  output logic [11:0]              caddr_rd,
  input  logic signed [DATA_W-1:0] cdata_rd,
  output logic [2:0]               csel,
  output logic                     cwr,
  output logic [11:0]              caddr_wr,
  output logic [DATA_W-1:0]        cdata_wr,
  output logic                     wrd,
  output logic [WADDR_W-1:0]       waddr,
  input  logic signed [DATA_W-1:0] wdata
);
  localparam int I_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int O_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam logic [WADDR_W-1:0] BIAS_BASE = WADDR_W'(NUM_OUT * IN_LEN);

  fc_state_t                state;
  logic [I_W-1:0]           i_cnt;
  logic [O_W-1:0]           o_cnt;
  logic [WADDR_W-1:0]       w_ptr;
  logic                     vld_p1;
  logic signed [ACC_W-1:0]  acc;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [DATA_W-1:0] rs_out;

  assign prod     = cdata_rd * wdata;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-DATA_W-FRAC_W){wdata[DATA_W-1]}}, wdata, {FRAC_W{1'b0}}};

  fc_round_sat #(.RELU(RELU)) u_round_sat (
    .acc (acc),
    .y   (rs_out)
  );

  // Weights for consecutive neurons are contiguous, so w_ptr simply keeps
  // counting across outputs and equals o*IN_LEN+i at every read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      crd      <= 1'b0;
      caddr_rd <= '0;
      csel     <= '0;
      cwr      <= 1'b0;
      caddr_wr <= '0;
      cdata_wr <= '0;
      wrd      <= 1'b0;
      waddr    <= '0;
      i_cnt    <= '0;
      o_cnt    <= '0;
      w_ptr    <= '0;
      vld_p1   <= 1'b0;
      acc      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          cwr  <= 1'b0;
          csel <= '0;
          if (start) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            i_cnt <= '0;
            o_cnt <= '0;
            w_ptr <= '0;
            acc   <= '0;
          end
        end
        ST_RUN: begin
          crd      <= 1'b1;
          wrd      <= 1'b1;
          cwr      <= 1'b0;
          csel     <= IN_SEL;
          caddr_rd <= 12'(i_cnt);
          waddr    <= w_ptr;
          w_ptr    <= w_ptr + 1'b1;
          vld_p1   <= 1'b1;
          if (vld_p1) acc <= acc + prod_ext;
          if (i_cnt == I_W'(IN_LEN - 1)) begin
            i_cnt <= '0;
            state <= ST_BIAS;
          end else begin
            i_cnt <= i_cnt + 1'b1;
          end
        end
        // ---- last product lands while the bias word is fetched ----
        ST_BIAS: begin
          crd    <= 1'b0;
          wrd    <= 1'b1;
          csel   <= '0;
          waddr  <= BIAS_BASE + WADDR_W'(o_cnt);
          vld_p1 <= 1'b0;
          if (vld_p1) acc <= acc + prod_ext;
          state  <= ST_ADD_BIAS;
        end
        ST_ADD_BIAS: begin
          wrd   <= 1'b0;
          acc   <= acc + bias_ext;
          state <= ST_WRITE;
        end
        // ---- result write-back ----
        ST_WRITE: begin
          cwr      <= 1'b1;
          caddr_wr <= 12'(o_cnt);
          csel     <= OUT_SEL;
          cdata_wr <= rs_out;
          acc      <= '0;
          i_cnt    <= '0;
          if (o_cnt == O_W'(NUM_OUT - 1)) begin
            state <= ST_DONE;
          end else begin
            o_cnt <= o_cnt + 1'b1;
            state <= ST_RUN;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          cwr   <= 1'b0;
          csel  <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: memory/ROM models, dot-product reference model
// and a monitor that checks every write against queued expectations.
module tb_fc_layer;
  localparam int IN_LEN  = 2048;
  localparam int NUM_OUT = 4;
  localparam int WN      = NUM_OUT * IN_LEN + NUM_OUT;
  localparam int PER     = IN_LEN + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, crd, cwr, wrd;
  logic [11:0] caddr_rd, caddr_wr;
  logic [19:0] cdata_rd = '0;
  logic [19:0] cdata_wr;
  logic [2:0]  csel;
  logic [13:0] waddr;
  logic [19:0] wdata = '0;

  logic [19:0] in_mem [IN_LEN];
  logic [19:0] w_mem  [WN];

  typedef struct {
    logic [11:0] addr;
    logic [19:0] data;
    int          edge_n;
  } exp_t;
  exp_t exp_q[$];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int proto_err = 0;

  fc_layer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .cdata_rd (cdata_rd),
    .csel     (csel),
    .cwr      (cwr),
    .caddr_wr (caddr_wr),
    .cdata_wr (cdata_wr),
    .wrd      (wrd),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memories answer during the cycle after the strobe; junk otherwise.
  always @(negedge clk) begin
    cdata_rd = crd ? in_mem[caddr_rd[10:0]] : 20'($urandom);
    wdata    = (wrd && int'(waddr) < WN) ? w_mem[waddr] : 20'($urandom);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (cwr) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", caddr_wr, e.addr);
          check("wr_data", cdata_wr, e.data);
          check("wr_edge", cyc, e.edge_n);
        end
      end
      if ((crd && cwr) || (crd && csel != 3'b101) || (cwr && csel != 3'b110) ||
          (!crd && !cwr && csel != 3'b000))
        proto_err++;
    end
  end

  function automatic logic [19:0] model(input int o);
    longint acc, y;
    acc = 0;
    for (int i = 0; i < IN_LEN; i++)
      acc += longint'($signed(in_mem[i])) * longint'($signed(w_mem[o*IN_LEN+i]));
    acc += longint'($signed(w_mem[NUM_OUT*IN_LEN+o])) * 65536;
    y = (acc + 32768) >>> 16;
    if (y > 524287) y = 524287;
    if (y < -524288) y = -524288;
    if (y < 0) y = 0;
    return 20'(y);
  endfunction

  task automatic fill(input logic [19:0] iv, input logic [19:0] wv, input logic [19:0] bv);
    for (int i = 0; i < IN_LEN; i++) in_mem[i] = iv;
    for (int i = 0; i < NUM_OUT * IN_LEN; i++) w_mem[i] = wv;
    for (int o = 0; o < NUM_OUT; o++) w_mem[NUM_OUT*IN_LEN+o] = bv;
  endtask

  task automatic kick(output int t0);
    @(negedge clk);
    t0 = cyc + 1;
    proto_err = 0;
    for (int k = 0; k < NUM_OUT; k++)
      exp_q.push_back('{addr: 12'(k), data: model(k), edge_n: t0 + (k + 1) * PER});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic run_case(input string nm, input bit stray_start);
    int t0, n;
    kick(t0);
    if (stray_start) begin
      repeat (99) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    n = 0;
    while (!done && n < NUM_OUT * PER + 50) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_done_edge"}, cyc, t0 + NUM_OUT * PER + 1);
    check({nm, "_busy_fall"}, busy, 0);
    @(negedge clk);
    check({nm, "_done_pulse"}, done, 0);
    check({nm, "_writes_left"}, exp_q.size(), 0);
    check({nm, "_bus_protocol"}, proto_err, 0);
    exp_q.delete();
  endtask

  initial begin
    int t0;
    fill('0, '0, '0);
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, crd, caddr_rd, csel, cwr, caddr_wr, cdata_wr, wrd, waddr}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    fill('0, '0, '0);
    w_mem[NUM_OUT*IN_LEN+0] = 20'h01000;
    w_mem[NUM_OUT*IN_LEN+1] = 20'hFF000;
    w_mem[NUM_OUT*IN_LEN+2] = 20'h00000;
    w_mem[NUM_OUT*IN_LEN+3] = 20'h7FFFF;
    check("model_bias", model(0), 20'h01000);
    run_case("bias_only", 1'b0);

    fill(20'h10000, 20'h00010, '0);
    run_case("half", 1'b1);

    fill(20'h7FFFF, 20'h7FFFF, '0);
    run_case("pos_sat", 1'b0);

    fill(20'h7FFFF, 20'h80000, '0);
    run_case("neg_relu", 1'b0);

    fill('0, '0, '0);
    for (int i = 0; i < NUM_OUT * IN_LEN; i++) w_mem[i] = 20'($urandom);
    in_mem[0] = 20'h00001;
    w_mem[0*IN_LEN] = 20'h08000;
    w_mem[1*IN_LEN] = 20'hF8000;
    w_mem[2*IN_LEN] = 20'h07FFF;
    w_mem[3*IN_LEN] = 20'h18000;
    run_case("rounding", 1'b0);

    for (int i = 0; i < IN_LEN; i++) in_mem[i] = 20'($signed(13'($urandom)));
    for (int i = 0; i < NUM_OUT * IN_LEN; i++) w_mem[i] = 20'($signed(13'($urandom)));
    for (int o = 0; o < NUM_OUT; o++) w_mem[NUM_OUT*IN_LEN+o] = 20'($urandom);
    run_case("random", 1'b0);

    // Abort mid-run, then recompute the bias-only vectors from scratch.
    fill('0, '0, '0);
    w_mem[NUM_OUT*IN_LEN+0] = 20'h01000;
    w_mem[NUM_OUT*IN_LEN+1] = 20'hFF000;
    w_mem[NUM_OUT*IN_LEN+2] = 20'h00000;
    w_mem[NUM_OUT*IN_LEN+3] = 20'h7FFFF;
    kick(t0);
    while (cyc < t0 + 2999) @(negedge clk);
    check("pre_abort_writes", exp_q.size(), NUM_OUT - 1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_outputs", {busy, done, crd, csel, cwr, wrd}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    run_case("after_reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
